// File: rtl/hazard_controller.sv
// hazard_controller: load-use, ID-branch and mult/div interlocks with a saturating stall counter
module hazard_controller #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_is_md,
  input  logic             id_reads_hilo,
  input  logic             branch_taken,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_rw,
  input  logic [4:0]       id_ex_wr,
  input  logic             ex_mem_mem_read,
  input  logic [4:0]       ex_mem_wr,
  input  logic             md_start,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);
  typedef enum logic {RUN, BR_WAIT} state_t;
  state_t state, state_nx;
  logic [5:0] md_cnt;
  logic load_use, br_ex, br_load, br_mem, md_hazard, stall;
  function automatic logic match(input logic [4:0] r);
    return (r != 5'd0) && (r == id_rs || (id_uses_rt && r == id_rt));
  endfunction
  always_comb begin
    load_use     = id_ex_mem_read && match(id_ex_wr);
    br_ex        = id_is_branch && id_ex_rw && !id_ex_mem_read && match(id_ex_wr);
    br_load      = id_is_branch && id_ex_mem_read && match(id_ex_wr);
    br_mem       = id_is_branch && ex_mem_mem_read && match(ex_mem_wr);
    md_hazard    = md_busy && (id_is_md || id_reads_hilo);
    stall        = (state == BR_WAIT) || load_use || br_ex || br_load || br_mem || md_hazard;
    state_nx     = (state == RUN && br_load) ? BR_WAIT : RUN;
    // reset overrides everything so the pipeline holds while reset_n is low
    pc_write     = reset_n && !stall;
    if_id_write  = reset_n && !stall;
    id_ex_bubble = !reset_n || stall;
    if_id_flush  = reset_n && !stall && id_is_branch && branch_taken;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      md_busy      <= 1'b0;
      md_cnt       <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nx;
      if (md_busy) begin
        if (md_cnt == 6'd0) md_busy <= 1'b0;
        else md_cnt <= md_cnt - 6'd1;
      end else if (md_start) begin
        md_cnt  <= 6'(MD_LATENCY - 1);
        md_busy <= 1'b1;
      end
      if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
    end
  end
endmodule
